// File: rtl/eightytwos_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eightytwos_bus_pkg
// Brief    : Shared types and constants for the Eighty_Twos memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package eightytwos_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    localparam logic [7:0] RDATA_OOR = 8'hFF;

    localparam int c_DEF_ADDR_W      = 16;
    localparam int c_DEF_DEPTH       = 256;
    localparam int c_DEF_WAIT_CYCLES = 2;
    localparam int c_DEF_SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/eightytwos_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : eightytwos_mem_responder_if
// Brief    : Core-side data bus (four-phase req/ack) between core and responder.
// Revision : 1.0 - initial release
// ============================================================================
interface eightytwos_mem_responder_if
    import eightytwos_bus_pkg::*;
#(
    parameter int ADDR_W = c_DEF_ADDR_W
) ();

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic [7:0]        bus_rdata;
    logic              bus_data_oe;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_data_oe, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_data_oe, bus_ack
    );

endinterface
`default_nettype wire

// File: rtl/eightytwos_resp_ram.sv
`default_nettype none
// ============================================================================
// Module   : eightytwos_resp_ram
// Brief    : Single-port DEPTH x 8 byte RAM, synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module eightytwos_resp_ram
    import eightytwos_bus_pkg::*;
#(
    parameter int DEPTH = c_DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_addr,
    input  wire logic [7:0]    i_wdata,
    output logic      [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read is combinational so the responder can register load data in ACCESS.
    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/eightytwos_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : eightytwos_mem_responder
// Brief    : Four-phase req/ack target servicing core loads/stores from a RAM.
// Revision : 1.0 - initial release
// ============================================================================
module eightytwos_mem_responder
    import eightytwos_bus_pkg::*;
#(
    parameter int ADDR_W      = c_DEF_ADDR_W,
    parameter int DEPTH       = c_DEF_DEPTH,
    parameter int WAIT_CYCLES = c_DEF_WAIT_CYCLES,
    parameter int SYNC_STAGES = c_DEF_SYNC_STAGES
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    eightytwos_mem_responder_if.slave     bus,
    input  wire logic                     load_en,
    input  wire logic [$clog2(DEPTH)-1:0] load_addr,
    input  wire logic [7:0]               load_data,
    output logic                          load_busy,
    output logic                          err
);

    localparam int                  c_RAM_AW    = $clog2(DEPTH);
    localparam int                  c_CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [ADDR_W:0]     c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_CNT_W-1:0]  c_CNT_INIT  = c_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    w_req_s;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_we;
    logic [7:0]              r_wdata;
    logic [7:0]              r_rdata;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_err;
    logic                    w_in_range;
    logic                    w_ack;
    logic                    w_oe;
    logic                    w_ram_we;
    logic [c_RAM_AW-1:0]     w_ram_addr;
    logic [7:0]              w_ram_wdata;
    logic [7:0]              w_ram_rdata;

    assign w_req_s    = r_sync[SYNC_STAGES-1];
    // Full-width compare: high address bits never alias into the RAM.
    assign w_in_range = ({1'b0, r_addr} < c_DEPTH_EXT);
    assign load_busy  = (r_state != ST_IDLE) | w_req_s;

    // Bus owns the RAM port in ACCESS; otherwise the preload port may write.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = load_addr;
        w_ram_wdata = load_data;
        if (r_state == ST_ACCESS) begin
            w_ram_addr  = r_addr[c_RAM_AW-1:0];
            w_ram_wdata = r_wdata;
            w_ram_we    = r_we & w_in_range & ~rst;
        end else begin
            w_ram_we    = load_en & ~load_busy & ~rst;
        end
    end

    eightytwos_resp_ram #(
        .DEPTH (DEPTH),
        .AW    (c_RAM_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_oe        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s) begin
                    w_state_nxt = (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_state_nxt = ST_ACK;
            end
            ST_ACK: begin
                w_ack = 1'b1;
                w_oe  = ~r_we;
                // Leaving only on a low req_s prevents a held request retriggering.
                if (!w_req_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= 8'h00;
            r_cnt   <= '0;
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.bus_req};
            case (r_state)
                ST_IDLE: begin
                    if (w_req_s) begin
                        r_addr  <= bus.bus_addr;
                        r_we    <= bus.bus_we;
                        r_wdata <= bus.bus_wdata;
                        r_cnt   <= c_CNT_INIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_in_range ? w_ram_rdata : RDATA_OOR;
                    end
                    if (!w_in_range) begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.bus_ack     = w_ack;
    assign bus.bus_data_oe = w_oe;
    assign bus.bus_rdata   = r_rdata;
    assign err             = r_err;

endmodule
`default_nettype wire

// File: doc/eightytwos_mem_responder.md
Name: eightytwos_mem_responder

Overview:
Target-side memory responder for the Eighty_Twos 8-bit core's external data bus (the other end of the core's store_en-gated 8-pin data interface). It accepts the core's requests over a four-phase req/ack handshake and services them from an internal byte RAM: it captures store data when `bus_we`=1 and drives load data back when `bus_we`=0. It is used on the harness or companion side of the GPIO breakout so the core can run programs without external hardware. A host preload port fills the RAM while the bus is idle.

Parameters:
- ADDR_W, 16: width of the bus address.
- DEPTH, 256: number of RAM bytes. Addresses >= DEPTH are out of range.
- WAIT_CYCLES, 2: inserted wait states before the access (0 allowed).
- SYNC_STAGES, 2: flops in the `bus_req` synchronizer (>= 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- bus_req  input  1  core request strobe (pin level; synchronized internally)
- bus_we  input  1  1 = store (the core's store_en), 0 = load
- bus_addr  input  ADDR_W  byte address, stable while bus_req=1
- bus_wdata  input  8  store data from the core, stable while bus_req=1
- bus_rdata  output  8  load data to the core
- bus_data_oe  output  1  1 = responder drives the data pins (load in ACK only)
- bus_ack  output  1  handshake acknowledge
- load_en  input  1  host preload write strobe
- load_addr  input  $clog2(DEPTH)  preload address
- load_data  input  8  preload data
- load_busy  output  1  preload write will be dropped this cycle
- err  output  1  sticky flag: an out-of-range access occurred

Behaviour:
- Reset values: state=IDLE, bus_ack=0, bus_data_oe=0, bus_rdata=8'h00, err=0, synchronizer flops=0. RAM contents are not reset.
- req_s is the bus_req signal after SYNC_STAGES flops. bus_addr, bus_we and bus_wdata are sampled unsynchronized; the protocol holds them stable.
- FSM states: IDLE, WAIT, ACCESS, ACK.
- IDLE, req_s=1: latch addr/we/wdata. Load cnt=WAIT_CYCLES-1 and go to WAIT; if WAIT_CYCLES=0, go directly to ACCESS.
- WAIT: decrement cnt each cycle; when cnt=0, go to ACCESS. The WAIT state therefore lasts exactly WAIT_CYCLES cycles.
- ACCESS (one cycle):
  - Store, in range: mem[addr] <= wdata.
  - Load, in range: bus_rdata <= mem[addr].
  - Out of range: store is ignored; load returns 8'hFF; err <= 1.
  - Next state: ACK.
- ACK: bus_ack=1, bus_data_oe=~we_latched. Hold until req_s=0, then clear both on the next edge and go to IDLE.
- Latency: bus_ack rises SYNC_STAGES + WAIT_CYCLES + 2 edges after the first edge that samples bus_req=1. With defaults this is 6 edges.
- bus_ack falls SYNC_STAGES + 1 edges after bus_req falls.
- bus_rdata holds its last load value until the next load completes.
- A new request is not recognized until the FSM has returned to IDLE and req_s has been seen low. A bus_req held high does not retrigger.
- Address range check uses the full ADDR_W bits: in range iff addr < DEPTH. There is no wrap-around aliasing.
- load_busy = (state != IDLE) | req_s, combinational.
- load_en writes mem[load_addr] <= load_data only when load_busy=0.
- load_en and req_s in the same IDLE cycle: the bus wins and the preload write is dropped (load_busy=1 flags it).
- err clears only on rst.
- rst mid-transaction:
  - FSM returns to IDLE; ack and oe drop on that edge.
  - Any RAM write not yet in ACCESS is lost. A write already performed persists.

Decomposition:
- Package eightytwos_bus_pkg holds:
  - the state enum typedef;
  - constant RDATA_OOR = 8'hFF;
  - default parameter constants.
- One sub-module, eightytwos_resp_ram: single-port synchronous byte RAM, DEPTH x 8. The mux between bus port and preload port stays in the top.
- The synchronizer is inline.

Test Plan:
- Preload mem[0x10]=0xA5 with bus idle; load at addr 0x0010 -> bus_ack rises 6 edges after req, bus_rdata=0xA5, bus_data_oe=1 during ACK, both clear 3 edges after req drops.
- Store 0x3C to 0x0020, then load 0x0020 -> rdata=0x3C; bus_data_oe stays 0 throughout the store.
- Load from 0x0100 (DEPTH=256) -> rdata=0xFF, err=1 and stays 1. Store to 0x0100 does not alter mem[0x00].
- WAIT_CYCLES=0 build: load latency is 4 edges; hold req high for 20 cycles -> exactly one access, ack stays high until req drops.
- load_en asserted in the same cycle req_s first goes high -> load_busy=1, RAM not written by preload, bus access completes normally.
- Assert rst during WAIT of a store to 0x0005 -> ack never asserts, mem[0x05] unchanged, all outputs at reset values; the next transaction works normally.
